// File: rtl/win_frame_reader_pkg.sv
// ============================================================================
// Module  : win_frame_reader_pkg
// Brief   : Shared defaults, FSM state encoding and bit-reverse helper for the
//           window RAM frame reader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package win_frame_reader_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } wfr_state_e;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [15:0] bit_reverse(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < w) begin
                r[4'(i)] = v[4'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wfr_skid_fifo.sv
// ============================================================================
// Module  : wfr_skid_fifo
// Brief   : Two-entry FIFO (skid buffer) holding {last, index, data} beats.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wfr_skid_fifo
    import win_frame_reader_pkg::*;
#(
    parameter int WIDTH = 39
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_q;
    logic             rd_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             w_push;
    logic             w_pop;

    // A push into a full buffer is only taken when a pop frees a slot in the same cycle.
    always_comb begin
        w_pop   = pop_i & (count_q != 2'd0);
        w_push  = push_i & ((count_q != 2'd2) | w_pop);
        count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ~wr_q;
            end
            if (w_pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/win_frame_reader.sv
// ============================================================================
// Module  : win_frame_reader
// Brief   : Fetches one N-sample frame from the window RAM (natural or
//           bit-reversed order) and streams it out over valid/ready.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module win_frame_reader
    import win_frame_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BITREV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [ADDR_W-1:0] m_index_o,
    output logic              m_last_o
);

    localparam logic [ADDR_W:0] C_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam int              C_FW   = 1 + ADDR_W + DATA_W;

    wfr_state_e        state_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] infl_idx_q;
    logic              infl_last_q;
    logic              done_q;

    logic              w_pop;
    logic              w_room;
    logic              w_issue;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [1:0]        w_fifo_count;
    logic [C_FW-1:0]   w_fifo_din;
    logic [C_FW-1:0]   w_fifo_dout;

    // A slot is free when fewer than two samples are held or in flight; a pop in
    // the same cycle also frees one, which sustains one beat per cycle.
    always_comb begin
        w_pop   = m_valid_o & m_ready_i;
        w_room  = w_pop | (~w_fifo_full & ~((w_fifo_count == 2'd1) & inflight_q));
        w_issue = (state_q == ST_FETCH) & ~cnt_q[ADDR_W] & w_room;
        if (BITREV != 0) begin
            ram_addr_o = ADDR_W'(bit_reverse(16'(cnt_q[ADDR_W-1:0]), ADDR_W));
        end else begin
            ram_addr_o = cnt_q[ADDR_W-1:0];
        end
        if ((state_q == ST_IDLE) && start_i) begin
            cnt_d = '0;
        end else if (w_issue) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            infl_idx_q  <= '0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= w_issue;
            cnt_q      <= cnt_d;
            if (w_issue) begin
                infl_idx_q  <= ram_addr_o;
                infl_last_q <= (cnt_q == C_LAST);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_issue && (cnt_q == C_LAST)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && m_last_o) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign w_fifo_din = {infl_last_q, infl_idx_q, ram_dout_i};

    // Abort flushes the buffer and drops the read still in flight.
    wfr_skid_fifo #(
        .WIDTH (C_FW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (abort_i),
        .push_i  (inflight_q),
        .pop_i   (w_pop),
        .din_i   (w_fifo_din),
        .dout_o  (w_fifo_dout),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    assign ram_en_o  = w_issue;
    assign m_valid_o = ~w_fifo_empty;
    assign m_data_o  = w_fifo_dout[DATA_W-1:0];
    assign m_index_o = w_fifo_dout[DATA_W +: ADDR_W];
    assign m_last_o  = w_fifo_dout[C_FW-1];
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_win_frame_reader.sv
// ============================================================================
// Module  : tb_win_frame_reader
// Brief   : Self-checking bench; natural-order and bit-reversed instances run
//           in lockstep from shared start/abort/ready stimulus.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_win_frame_reader;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int N  = 64;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;
    logic m_ready;

    logic [1:0]    busy;
    logic [1:0]    done;
    logic [1:0]    ram_en;
    logic [1:0]    m_valid;
    logic [1:0]    m_last;
    logic [AW-1:0] ram_addr [2];
    logic [DW-1:0] ram_dout [2];
    logic [DW-1:0] m_data   [2];
    logic [AW-1:0] m_index  [2];

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] i;
        logic          l;
        int            c;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    int              held       [2];
    bit              stall_prev [2];
    logic [DW+AW:0]  pay_prev   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    win_frame_reader #(.DATA_W(DW), .ADDR_W(AW), .BITREV(0)) u_nat (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .busy_o(busy[0]), .done_o(done[0]), .ram_en_o(ram_en[0]),
        .ram_addr_o(ram_addr[0]), .ram_dout_i(ram_dout[0]),
        .m_valid_o(m_valid[0]), .m_ready_i(m_ready), .m_data_o(m_data[0]),
        .m_index_o(m_index[0]), .m_last_o(m_last[0])
    );

    win_frame_reader #(.DATA_W(DW), .ADDR_W(AW), .BITREV(1)) u_rev (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .busy_o(busy[1]), .done_o(done[1]), .ram_en_o(ram_en[1]),
        .ram_addr_o(ram_addr[1]), .ram_dout_i(ram_dout[1]),
        .m_valid_o(m_valid[1]), .m_ready_i(m_ready), .m_data_o(m_data[1]),
        .m_index_o(m_index[1]), .m_last_o(m_last[1])
    );

    // Window RAM content: word at address a holds 0x1000 + a.
    always @(posedge clk) begin
        if (ram_en[0]) ram_dout[0] <= 32'h1000 + 32'(ram_addr[0]);
        if (ram_en[1]) ram_dout[1] <= 32'h1000 + 32'(ram_addr[1]);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rev_idx(input int k);
        int r = 0;
        for (int j = 0; j < AW; j++) begin
            if (((k >> j) & 1) != 0) r += 1 << (AW - 1 - j);
        end
        return r;
    endfunction

    // Beat collector, stall-stability and at-most-two-outstanding checks.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                held[s]       = 0;
                stall_prev[s] = 1'b0;
            end else begin
                if (stall_prev[s]) begin
                    check("stall_valid_held", m_valid[s], 1);
                    check("stall_payload_stable", {m_last[s], m_index[s], m_data[s]}, pay_prev[s]);
                end
                if (m_valid[s] && m_ready && !abort) begin
                    beat_t b;
                    b.d = m_data[s];
                    b.i = m_index[s];
                    b.l = m_last[s];
                    b.c = cyc;
                    if (s == 0) q0.push_back(b); else q1.push_back(b);
                    held[s]--;
                end
                if (abort) begin
                    held[s] = 0;
                end else if (ram_en[s]) begin
                    held[s]++;
                    check("outstanding_le_2", held[s] <= 2, 1);
                end
                stall_prev[s] = m_valid[s] && !m_ready && !abort;
                pay_prev[s]   = {m_last[s], m_index[s], m_data[s]};
            end
        end
        if (!rst && done[0]) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_busy_low", busy, 0);
            check("done_lockstep", done[1], 1);
        end
    end

    task automatic check_frame(input int base, input bit consec);
        check("frame_len_nat", q0.size() >= base + N, 1);
        check("frame_len_rev", q1.size() >= base + N, 1);
        if (q0.size() >= base + N && q1.size() >= base + N) begin
            for (int i = 0; i < N; i++) begin
                beat_t a;
                beat_t b;
                a = q0[base + i];
                b = q1[base + i];
                check("nat_index", a.i, i);
                check("nat_data", a.d, 32'h1000 + i);
                check("nat_last", a.l, (i == N - 1));
                check("rev_index", b.i, rev_idx(i));
                check("rev_data", b.d, 32'h1000 + rev_idx(i));
                check("rev_last", b.l, (i == N - 1));
                if (consec && i > 0) check("consecutive_beats", a.c - q0[base + i - 1].c, 1);
            end
        end
    endtask

    // mode 1: random 30% ready with a single 20-cycle stall once 10 beats are in.
    task automatic wait_done(input int target, input int budget, input int mode);
        int stall = 0;
        bit stalled_once = 1'b0;
        for (int k = 0; k < budget && done_cnt < target; k++) begin
            @(posedge clk); #1;
            if (mode == 1) begin
                if (!stalled_once && q0.size() >= 10) begin
                    stalled_once = 1'b1;
                    stall = 20;
                end
                if (stall > 0) begin
                    m_ready = 1'b0;
                    stall--;
                end else begin
                    m_ready = ($urandom_range(0, 99) < 30);
                end
            end
        end
        check("done_within_budget", done_cnt >= target, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int d;
        bit found;
        rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_addr", ram_addr[1], 0);
        check("rst_data", m_data[0], 0);
        check("rst_index", m_index[1], 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-rate frame with first-valid latency.
        q0.delete(); q1.delete();
        m_ready = 1'b1;
        pulse_start();
        check("busy_after_start", busy, 2'b11);
        check("valid_e0", m_valid, 0);
        check("ram_en_e0", ram_en, 2'b11);
        @(posedge clk); #1;
        check("valid_e1", m_valid, 0);
        @(posedge clk); #1;
        check("valid_e2", m_valid, 2'b11);
        wait_done(1, 300, 0);
        check_frame(0, 1'b1);
        check("exact_beats_t1", q0.size(), N);
        if (q0.size() >= N) check("done_after_last", done_cyc, q0[N-1].c + 1);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);

        // Random backpressure with a long stall.
        q0.delete(); q1.delete();
        pulse_start();
        wait_done(2, 3000, 1);
        m_ready = 1'b1;
        check_frame(0, 1'b0);
        check("exact_beats_random", q0.size(), N);

        // Abort mid-frame under backpressure.
        q0.delete(); q1.delete();
        m_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 200 && q0.size() < 20; k++) begin
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        @(posedge clk); #1;
        check("valid_before_abort", m_valid, 2'b11);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        d = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, d);
        check("beats_before_abort", q0.size(), 20);
        q0.delete(); q1.delete();
        m_ready = 1'b1;
        pulse_start();
        wait_done(d + 1, 300, 0);
        check_frame(0, 1'b1);

        // Asynchronous reset during FETCH, then start ignored while busy.
        q0.delete(); q1.delete();
        m_ready = 1'b0;
        pulse_start();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", m_valid, 0);
        check("arst_ram_en", ram_en, 0);
        check("arst_done", done, 0);
        check("arst_last", m_last, 0);
        check("arst_addr_nat", ram_addr[0], 0);
        check("arst_addr_rev", ram_addr[1], 0);
        check("arst_data", m_data[0], 0);
        check("arst_index", m_index[1], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("arst_stays_idle", busy, 0);
        q0.delete(); q1.delete();
        d = done_cnt;
        m_ready = 1'b1;
        pulse_start();
        repeat (30) @(posedge clk);
        #1;
        pulse_start();
        check("busy_start_ignored", busy, 2'b11);
        wait_done(d + 1, 300, 0);
        check_frame(0, 1'b1);
        check("exact_beats_restart", q0.size(), N);
        repeat (10) @(posedge clk);
        #1;
        check("single_done", done_cnt, d + 1);

        // Start during the done pulse launches a back-to-back frame.
        q0.delete(); q1.delete();
        d = done_cnt;
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (done[0]) begin
                found = 1'b1;
                break;
            end
        end
        check("done_seen", found, 1);
        pulse_start();
        check("b2b_busy", busy, 2'b11);
        check("b2b_valid_e0", m_valid, 0);
        @(posedge clk); #1;
        check("b2b_valid_e1", m_valid, 0);
        @(posedge clk); #1;
        check("b2b_valid_e2", m_valid, 2'b11);
        wait_done(d + 2, 300, 0);
        check("b2b_total_beats", q0.size(), 2 * N);
        check_frame(0, 1'b1);
        check_frame(N, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_two_dones", done_cnt, d + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
